// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker state encoding, default taps and the
// tap XOR used by both the generator and the checker.
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_e;

  // x^8 + x^6 + x^5 + x^4 + 1, indexed [1:8]
  localparam logic [7:0] TAPS8 = 8'b00011101;

  localparam int TAP_MAX = 32;

  function automatic logic tap_xor(input logic [TAP_MAX-1:0] hist,
                                   input logic [TAP_MAX-1:0] taps);
    return ^(hist & taps);
  endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter; a clear and an increment in the same cycle
// yield 1, because the clear is applied before the increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d, base;

  always_comb begin
    base  = clr_i ? '0 : cnt_q;
    cnt_d = base;
    if (inc_i && (base != {W{1'b1}})) begin
      cnt_d = base + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker: seeds from the line, hunts for LOCK_N
// consecutive predicted bits, then flywheels the sequence and counts errors.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int         n        = 8,
  parameter logic [1:n] TAPS     = TAPS8,
  parameter int         LOCK_N   = 16,
  parameter int         UNLOCK_N = 4,
  parameter int         CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din,
  input  logic          din_valid,
  input  logic          clr_cnt,
  output logic          locked,
  output logic          err_pulse,
  output logic [CW-1:0] err_cnt
);

  localparam int SW = $clog2(n + 1);
  localparam int MW = $clog2(LOCK_N + 1);
  localparam int UW = $clog2(UNLOCK_N + 1);

  lfsr_state_e    state_q, state_d;
  logic [1:n]     h_q, h_d;
  logic [SW-1:0]  seed_cnt;
  logic [MW-1:0]  match_cnt;
  logic [UW-1:0]  cons_cnt;
  logic           exp_bit, match, h_zero, hunt_good, lock_err;
  logic           locked_q, err_pulse_q;
  logic           seed_inc, seed_clr, match_inc, match_clr, cons_inc, cons_clr;

  assign exp_bit   = tap_xor(TAP_MAX'(h_q), TAP_MAX'(TAPS));
  assign match     = (din == exp_bit);
  assign h_zero    = (h_q == '0);
  // An all-zero history trivially predicts zeros, so it must never count toward lock.
  assign hunt_good = match && !h_zero;
  assign lock_err  = din_valid && (state_q == LOCKED) && !match;

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    seed_inc  = 1'b0;
    seed_clr  = 1'b0;
    match_inc = 1'b0;
    match_clr = 1'b0;
    cons_inc  = 1'b0;
    cons_clr  = 1'b0;
    if (din_valid) begin
      case (state_q)
        SEED: begin
          h_d       = {din, h_q[1:n-1]};
          seed_inc  = 1'b1;
          match_clr = 1'b1;
          if (seed_cnt == SW'(n - 1)) state_d = HUNT;
        end
        HUNT: begin
          h_d      = {din, h_q[1:n-1]};
          cons_clr = 1'b1;
          if (hunt_good) begin
            match_inc = 1'b1;
            if (match_cnt == MW'(LOCK_N - 1)) state_d = LOCKED;
          end else begin
            match_clr = 1'b1;
          end
        end
        LOCKED: begin
          // Flywheel on the prediction so one line error is counted exactly once.
          h_d = {exp_bit, h_q[1:n-1]};
          if (match) begin
            cons_clr = 1'b1;
          end else begin
            cons_inc = 1'b1;
            if (cons_cnt == UW'(UNLOCK_N - 1)) begin
              state_d  = SEED;
              seed_clr = 1'b1;
            end
          end
        end
        default: state_d = SEED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SEED;
      h_q         <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      locked_q    <= (state_d == LOCKED);
      err_pulse_q <= lock_err;
    end
  end

  sat_counter #(.W(SW)) u_seed_cnt (
    .clk(clk), .rst_n(rst), .clr_i(seed_clr), .inc_i(seed_inc), .cnt_o(seed_cnt)
  );

  sat_counter #(.W(MW)) u_match_cnt (
    .clk(clk), .rst_n(rst), .clr_i(match_clr), .inc_i(match_inc), .cnt_o(match_cnt)
  );

  sat_counter #(.W(UW)) u_cons_cnt (
    .clk(clk), .rst_n(rst), .clr_i(cons_clr), .inc_i(cons_inc), .cnt_o(cons_cnt)
  );

  sat_counter #(.W(CW)) u_err_cnt (
    .clk(clk), .rst_n(rst), .clr_i(clr_cnt), .inc_i(lock_err), .cnt_o(err_cnt)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (default, and CW=4 with a large
// UNLOCK_N) share one randomised stream; a scoreboard checks every cycle.
module tb_lfsr_checker;

  localparam int N      = 8;
  localparam int LOCK_N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked0, pulse0, locked1, pulse1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  always #5 clk = ~clk;

  lfsr_checker #(.n(8), .TAPS(8'b00011101), .LOCK_N(16), .UNLOCK_N(4), .CW(16)) dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .locked(locked0), .err_pulse(pulse0), .err_cnt(cnt0)
  );

  lfsr_checker #(.n(8), .TAPS(8'b00011101), .LOCK_N(16), .UNLOCK_N(64), .CW(4)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .locked(locked1), .err_pulse(pulse1), .err_cnt(cnt1)
  );

  typedef struct {
    bit l0; bit p0; int c0;
    bit l1; bit p1; int c1;
    int beat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   lock_beat = -1;
  int   vb        = 0;

  // Reference model: mode 0 = seeding, 1 = hunting, 2 = locked.
  int          m_mode[2], m_seed[2], m_run[2], m_cons[2], m_err[2];
  bit          m_pulse[2];
  logic [63:0] m_past[2];
  int          unlock_lim[2] = '{4, 64};
  int          err_max[2]    = '{65535, 15};

  // Generator history: bit k-1 is the bit emitted k beats ago.
  bit [7:0] g_past;

  function automatic bit gen_next();
    bit b;
    b = g_past[3] ^ g_past[4] ^ g_past[5] ^ g_past[7];
    g_past = {g_past[6:0], b};
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int exp_v);
    n_checks++;
    if (act !== 32'(exp_v)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (beat %0d)", name, act, exp_v, vb);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_seed[i] = 0; m_run[i] = 0; m_cons[i] = 0;
      m_err[i] = 0; m_pulse[i] = 0; m_past[i] = '0;
    end
  endtask

  task automatic model_step(input int i, input bit d, input bit v, input bit c);
    bit e, hit;
    m_pulse[i] = 0;
    if (c) m_err[i] = 0;
    if (!v) return;
    // Polynomial x^8+x^6+x^5+x^4+1: bit k is the XOR of bits k-4, k-5, k-6, k-8.
    e   = m_past[i][3] ^ m_past[i][4] ^ m_past[i][5] ^ m_past[i][7];
    hit = (d == e);
    if (m_mode[i] == 0) begin
      m_past[i] = {m_past[i][62:0], d};
      m_seed[i]++;
      if (m_seed[i] == N) begin m_mode[i] = 1; m_run[i] = 0; end
    end else if (m_mode[i] == 1) begin
      if (hit && (m_past[i][N-1:0] != 0)) m_run[i]++;
      else m_run[i] = 0;
      m_past[i] = {m_past[i][62:0], d};
      if (m_run[i] == LOCK_N) begin m_mode[i] = 2; m_cons[i] = 0; end
    end else begin
      if (!hit) begin
        m_pulse[i] = 1;
        if (m_err[i] < err_max[i]) m_err[i]++;
        m_cons[i]++;
      end else begin
        m_cons[i] = 0;
      end
      m_past[i] = {m_past[i][62:0], e};
      if (m_cons[i] == unlock_lim[i]) begin m_mode[i] = 0; m_seed[i] = 0; end
    end
  endtask

  task automatic beat(input bit d, input bit v, input bit c);
    exp_t e;
    @(posedge clk); #1;
    din = d; din_valid = v; clr_cnt = c;
    if (v) vb++;
    model_step(0, d, v, c);
    model_step(1, d, v, c);
    e.l0 = (m_mode[0] == 2); e.p0 = m_pulse[0]; e.c0 = m_err[0];
    e.l1 = (m_mode[1] == 2); e.p1 = m_pulse[1]; e.c1 = m_err[1];
    e.beat = vb;
    exp_q.push_back(e);
  endtask

  task automatic send(input int count, input bit invert, input bit zero, input int gap_pct);
    bit b;
    for (int i = 0; i < count; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        beat(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end else begin
        b = zero ? 1'b0 : gen_next();
        beat(b ^ invert, 1'b1, 1'b0);
      end
    end
  endtask

  task automatic drain();
    @(posedge clk); #1;
    din_valid = 1'b0; clr_cnt = 1'b0; din = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    drain();
    #1 rst = 1'b0;
    #1;
    check("rst_locked0", locked0, 0);
    check("rst_pulse0", pulse0, 0);
    check("rst_cnt0", cnt0, 0);
    check("rst_locked1", locked1, 0);
    check("rst_cnt1", cnt1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    vb = 0;
  endtask

  initial begin : monitor
    exp_t e;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        @(negedge clk);
        check("locked0", locked0, int'(e.l0));
        check("pulse0", pulse0, int'(e.p0));
        check("cnt0", cnt0, e.c0);
        check("locked1", locked1, int'(e.l1));
        check("pulse1", pulse1, int'(e.p1));
        check("cnt1", cnt1, e.c1);
        if (locked0 && !prev) lock_beat = e.beat;
        prev = locked0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    g_past = 8'($urandom_range(1, 255));
    model_reset();
    do_reset();

    send(1000, 1'b0, 1'b0, 0); drain();
    check("lock_beat_clean", lock_beat, N + LOCK_N);
    check("clean_cnt0", cnt0, 0);
    check("clean_locked0", locked0, 1);

    send(1, 1'b1, 1'b0, 0); drain();
    check("single_cnt0", cnt0, 1);
    check("single_locked0", locked0, 1);

    send(20, 1'b0, 1'b0, 0);
    beat(gen_next(), 1'b1, 1'b1); drain();
    check("clr_cnt0", cnt0, 0);

    send(4, 1'b1, 1'b0, 0); drain();
    check("burst_cnt0", cnt0, 4);
    check("burst_locked0", locked0, 0);
    send(23, 1'b0, 1'b0, 0); drain();
    check("relock23_locked0", locked0, 0);
    send(1, 1'b0, 1'b0, 0); drain();
    check("relock24_locked0", locked0, 1);
    check("relock_cnt0", cnt0, 4);

    do_reset();
    send(500, 1'b0, 1'b1, 0); drain();
    check("zero_locked0", locked0, 0);
    check("zero_cnt0", cnt0, 0);
    check("zero_locked1", locked1, 0);

    do_reset();
    send(300, 1'b0, 1'b0, 50); drain();
    check("lock_beat_gaps", lock_beat, N + LOCK_N);
    check("gaps_locked0", locked0, 1);
    check("gaps_cnt0", cnt0, 0);

    do_reset();
    send(300, 1'b0, 1'b0, 50); drain();
    check("relock_rst_locked0", locked0, 1);
    check("relock_rst_locked1", locked1, 1);

    send(20, 1'b1, 1'b0, 0); drain();
    check("sat_cnt1", cnt1, 15);
    check("sat_locked1", locked1, 1);
    beat(gen_next() ^ 1'b1, 1'b1, 1'b1); drain();
    check("clr_err_cnt1", cnt1, 1);

    send(50, 1'b0, 1'b0, 0); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
